// File: rtl/regfile_bypass.sv
// Parametrised register file with a one-stage write staging register
// and optional forwarding of the staged write to the read ports.
module regfile_bypass #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     rd,
  input  logic [XLEN-1:0]   di,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] q,
  output logic              wb_pend
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] mem_q [NREG];

  logic            pend_v_q, pend_v_d;
  logic [AW-1:0]   pend_a_q, pend_a_d;
  logic [XLEN-1:0] pend_d_q, pend_d_d;

  always_comb begin
    pend_v_d = we && !(ZR && rd == '0);
    pend_a_d = pend_a_q;
    pend_d_d = pend_d_q;
    if (we) begin
      pend_a_d = rd;
      pend_d_d = di;
    end
  end

  // Commit of the previous staged write shares the edge with the next capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_d_q <= '0;
    end else begin
      if (pend_v_q) begin
        mem_q[pend_a_q] <= pend_d_q;
      end
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      pend_d_q <= pend_d_d;
    end
  end

  assign wb_pend = pend_v_q;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          zero;
    logic          hit;

    assign a    = ra[g*AW +: AW];
    assign zero = ZR && (a == '0);
    assign hit  = BP && pend_v_q
               && (pend_a_q == a);

    assign q[g*XLEN +: XLEN] =
      zero ? '0 :
      hit  ? pend_d_q :
             mem_q[a];
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench: a 4-port bypassing instance and a 2-port
// non-bypassing instance share the write port and low read addresses.
module tb_regfile_bypass;

  logic         clk;
  logic         rst;
  logic         we;
  logic [4:0]   rd;
  logic [31:0]  di;
  logic [19:0]  ra4;
  logic [9:0]   ra2;
  logic [127:0] q4;
  logic [63:0]  q2;
  logic         pend4;
  logic         pend2;

  int nvec;
  int nerr;

  assign ra2 = ra4[9:0];

  regfile_bypass #(
    .XLEN(32), .NREG(32), .AW(5),
    .NRD(4), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .we(we),
    .rd(rd), .di(di), .ra(ra4),
    .q(q4), .wb_pend(pend4)
  );

  regfile_bypass #(
    .XLEN(32), .NREG(32), .AW(5),
    .NRD(2), .ZERO_REG(1), .BYPASS(0)
  ) u_nb (
    .clk(clk), .rst(rst), .we(we),
    .rd(rd), .di(di), .ra(ra2),
    .q(q2), .wb_pend(pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [4:0] a);
    ra4 = {a, a, a, a};
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    we = 1'b1;
    rd = a;
    di = d;
    edge_step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    we  = 1'b0;
    rd  = '0;
    di  = '0;
    set_ra(5'd9);
    #2;
    nvec++;
    if (q4 !== 128'h0 || pend4 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_init q=%h pend=%b want 0",
               q4, pend4);
    end
    @(negedge clk);
    rst = 1'b1;
    edge_step();
    nvec++;
    if (q4 !== 128'h0 || q2 !== 64'h0) begin
      nerr++;
      $display("FAIL reset_release q4=%h q2=%h want 0",
               q4, q2);
    end
  endtask

  task automatic test_bypass_raw();
    set_ra(5'd5);
    wr(5'd5, 32'h1111_1111);
    edge_step();
    edge_step();
    #1;
    we = 1'b1;
    rd = 5'd5;
    di = 32'hDEAD_BEEF;
    #1;
    nvec++;
    if (q4[31:0] !== 32'h1111_1111 ||
        q2[31:0] !== 32'h1111_1111) begin
      nerr++;
      $display("FAIL raw_cycN q4=%h q2=%h want 11111111",
               q4[31:0], q2[31:0]);
    end
    edge_step();
    we = 1'b0;
    #1;
    nvec++;
    if (q4[31:0] !== 32'hDEAD_BEEF || pend4 !== 1'b1) begin
      nerr++;
      $display("FAIL raw_byp_N1 q=%h pend=%b want deadbeef/1",
               q4[31:0], pend4);
    end
    nvec++;
    if (q2[31:0] !== 32'h1111_1111 || pend2 !== 1'b1) begin
      nerr++;
      $display("FAIL raw_nb_N1 q=%h pend=%b want 11111111/1",
               q2[31:0], pend2);
    end
    edge_step();
    nvec++;
    if (q2[31:0] !== 32'hDEAD_BEEF ||
        q4[31:0] !== 32'hDEAD_BEEF ||
        pend4 !== 1'b0) begin
      nerr++;
      $display("FAIL raw_N2 q4=%h q2=%h pend=%b want deadbeef/0",
               q4[31:0], q2[31:0], pend4);
    end
  endtask

  task automatic test_zero_reg();
    set_ra(5'd0);
    wr(5'd0, 32'h1234_5678);
    #1;
    nvec++;
    if (pend4 !== 1'b0 || q4 !== 128'h0 || q2 !== 64'h0) begin
      nerr++;
      $display("FAIL zero_N1 pend=%b q4=%h q2=%h want 0",
               pend4, q4, q2);
    end
    edge_step();
    edge_step();
    nvec++;
    if (q4 !== 128'h0 || q2 !== 64'h0) begin
      nerr++;
      $display("FAIL zero_later q4=%h q2=%h want 0", q4, q2);
    end
  endtask

  task automatic test_back_to_back();
    set_ra(5'd7);
    wr(5'd7, 32'h1);
    we = 1'b1;
    rd = 5'd7;
    di = 32'h2;
    #1;
    nvec++;
    if (q4[31:0] !== 32'h1 || pend4 !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_N1 q=%h pend=%b want 1/1",
               q4[31:0], pend4);
    end
    edge_step();
    we = 1'b0;
    #1;
    nvec++;
    if (q4[31:0] !== 32'h2 || q2[31:0] !== 32'h1) begin
      nerr++;
      $display("FAIL b2b_N2 q4=%h q2=%h want 2/1",
               q4[31:0], q2[31:0]);
    end
    edge_step();
    edge_step();
    nvec++;
    if (q4[31:0] !== 32'h2 || q2[31:0] !== 32'h2 ||
        pend4 !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_idle q4=%h q2=%h pend=%b want 2/2/0",
               q4[31:0], q2[31:0], pend4);
    end
  endtask

  task automatic test_reset_midrun();
    ra4 = {5'd7, 5'd5, 5'd7, 5'd5};
    #1;
    nvec++;
    if (q4 !== {32'h2, 32'hDEAD_BEEF, 32'h2, 32'hDEAD_BEEF}) begin
      nerr++;
      $display("FAIL mid_pre q4=%h want contents", q4);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (q4 !== 128'h0 || q2 !== 64'h0 ||
        pend4 !== 1'b0 || pend2 !== 1'b0) begin
      nerr++;
      $display("FAIL mid_rst q4=%h q2=%h pend=%b want 0",
               q4, q2, pend4);
    end
    we = 1'b1;
    rd = 5'd5;
    di = 32'hCAFE_F00D;
    edge_step();
    nvec++;
    if (q4 !== 128'h0 || pend4 !== 1'b0) begin
      nerr++;
      $display("FAIL mid_we_ign q4=%h pend=%b want 0",
               q4, pend4);
    end
    we  = 1'b0;
    rst = 1'b1;
    edge_step();
    edge_step();
    nvec++;
    if (q4 !== 128'h0 || q2 !== 64'h0) begin
      nerr++;
      $display("FAIL mid_post q4=%h q2=%h want 0", q4, q2);
    end
  endtask

  task automatic test_reset_mid_write();
    set_ra(5'd3);
    wr(5'd3, 32'hAAAA_5555);
    #1;
    nvec++;
    if (pend4 !== 1'b1 || q4[31:0] !== 32'hAAAA_5555) begin
      nerr++;
      $display("FAIL mw_staged pend=%b q=%h want 1/aaaa5555",
               pend4, q4[31:0]);
    end
    rst = 1'b0;
    #1;
    rst = 1'b1;
    edge_step();
    edge_step();
    nvec++;
    if (q4 !== 128'h0 || q2 !== 64'h0 || pend4 !== 1'b0) begin
      nerr++;
      $display("FAIL mw_dropped q4=%h q2=%h pend=%b want 0",
               q4, q2, pend4);
    end
  endtask

  task automatic test_sweep();
    logic [4:0]  a;
    logic [31:0] exp;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      rd = 5'(i);
      di = 32'(i);
      edge_step();
    end
    we = 1'b0;
    edge_step();
    edge_step();
    for (int j = 0; j < 8; j++) begin
      for (int p = 0; p < 4; p++) begin
        a = 5'(4 * j + p);
        ra4[p*5 +: 5] = a;
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        exp = 32'(4 * j + p);
        nvec++;
        if (q4[p*32 +: 32] !== exp) begin
          nerr++;
          $display("FAIL sweep_p%0d got=%h want=%h",
                   p, q4[p*32 +: 32], exp);
        end
      end
      edge_step();
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_bypass_raw();
    test_zero_reg();
    test_back_to_back();
    test_reset_midrun();
    test_reset_mid_write();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
